// File: rtl/time_set_pkg.sv
// time_set_pkg: FSM states, field indices, range limits and calendar helpers for time_set_ctrl.
package time_set_pkg;
    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;
    localparam logic [2:0] FLD_YEAR = 3'd0;
    localparam logic [2:0] FLD_MONT = 3'd1;
    localparam logic [2:0] FLD_DAY  = 3'd2;
    localparam logic [2:0] FLD_HOUR = 3'd3;
    localparam logic [2:0] FLD_MIN  = 3'd4;
    localparam logic [2:0] FLD_SEC  = 3'd5;
    localparam logic [2:0] FLD_NONE = 3'd7;
    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [3:0] MONT_MAX = 4'd12;
    function automatic logic is_leap(input logic [12:0] year);
        return (year % 13'd4 == 13'd0 && year % 13'd100 != 13'd0) || year % 13'd400 == 13'd0;
    endfunction
    function automatic logic [4:0] days_in_month(input logic [3:0] mont, input logic [12:0] year);
        return mont == 4'd2 ? (is_leap(year) ? 5'd29 : 5'd28) :
               (mont == 4'd4 || mont == 4'd6 || mont == 4'd9 || mont == 4'd11) ? 5'd30 : 5'd31;
    endfunction
    function automatic logic [12:0] wrap_step(input logic [12:0] v, input logic [12:0] lo,
                                              input logic [12:0] hi, input logic up);
        return up ? (v >= hi ? lo : v + 13'd1) : (v <= lo ? hi : v - 13'd1);
    endfunction
endpackage

// File: rtl/month_len.sv
// month_len: combinational days-in-month lookup with Gregorian leap-year rule.
module month_len
    import time_set_pkg::*;
(
    input  logic [3:0]  i_mont,
    input  logic [12:0] i_year,
    output logic [4:0]  o_dim
);
    assign o_dim = days_in_month(i_mont, i_year);
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: captures live time, edits it field by field with calendar validation, strobes load on commit.
// Optional TIME_SET_TIMEOUT_EN abandons an edit after TIMEOUT button-free cycles.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter logic [12:0] YEAR_MIN = 13'd2000,
`ifdef TIME_SET_TIMEOUT_EN
    parameter logic [7:0]  TIMEOUT  = 8'd30,
`endif
    parameter logic [12:0] YEAR_MAX = 13'd2099
)(
    input  logic        clk_1Hz,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [5:0]  cur_sec,
    input  logic [5:0]  cur_min,
    input  logic [4:0]  cur_hour,
    input  logic [4:0]  cur_day,
    input  logic [3:0]  cur_mont,
    input  logic [12:0] cur_year,
    output logic [5:0]  set_sec,
    output logic [5:0]  set_min,
    output logic [4:0]  set_hour,
    output logic [4:0]  set_day,
    output logic [3:0]  set_mont,
    output logic [12:0] set_year,
    output logic        load,
    output logic        editing,
    output logic [2:0]  field_sel
);
    state_t      r_state, w_state_n;
    logic [2:0]  r_fld, w_fld_n;
    logic [5:0]  w_sec_n, w_min_n;
    logic [4:0]  w_hour_n, w_day_c, w_day_n, w_dim;
    logic [3:0]  w_mont_n;
    logic [12:0] w_year_n;
    logic        w_cap, w_adj, w_up, w_timeout;
    assign w_cap = r_state == S_IDLE && btn_mode;
    assign w_adj = r_state == S_EDIT && !btn_mode && !btn_next && (btn_inc ^ btn_dec);
    assign w_up  = btn_inc;
    assign w_sec_n  = w_cap ? (cur_sec > SEC_MAX ? SEC_MAX : cur_sec) :
                      w_adj && r_fld == FLD_SEC ? 6'(wrap_step(13'(set_sec), 13'd0, 13'(SEC_MAX), w_up)) : set_sec;
    assign w_min_n  = w_cap ? (cur_min > MIN_MAX ? MIN_MAX : cur_min) :
                      w_adj && r_fld == FLD_MIN ? 6'(wrap_step(13'(set_min), 13'd0, 13'(MIN_MAX), w_up)) : set_min;
    assign w_hour_n = w_cap ? (cur_hour > HOUR_MAX ? HOUR_MAX : cur_hour) :
                      w_adj && r_fld == FLD_HOUR ? 5'(wrap_step(13'(set_hour), 13'd0, 13'(HOUR_MAX), w_up)) : set_hour;
    assign w_mont_n = w_cap ? (cur_mont == 4'd0 ? 4'd1 : cur_mont > MONT_MAX ? MONT_MAX : cur_mont) :
                      w_adj && r_fld == FLD_MONT ? 4'(wrap_step(13'(set_mont), 13'd1, 13'(MONT_MAX), w_up)) : set_mont;
    assign w_year_n = w_cap ? (cur_year < YEAR_MIN ? YEAR_MIN : cur_year > YEAR_MAX ? YEAR_MAX : cur_year) :
                      w_adj && r_fld == FLD_YEAR ? wrap_step(set_year, YEAR_MIN, YEAR_MAX, w_up) : set_year;
    // One lookup on the next-cycle date serves capture clamping, day wrap and post-change clamping
    month_len u_month_len (.i_mont(w_mont_n), .i_year(w_year_n), .o_dim(w_dim));
    assign w_day_c = w_cap ? (cur_day == 5'd0 ? 5'd1 : cur_day) :
                     w_adj && r_fld == FLD_DAY ? 5'(wrap_step(13'(set_day), 13'd1, 13'(w_dim), w_up)) : set_day;
    assign w_day_n = w_day_c > w_dim ? w_dim : w_day_c;
    assign w_fld_n = w_cap ? FLD_YEAR :
                     r_state == S_EDIT && !btn_mode && btn_next ? (r_fld == FLD_SEC ? FLD_YEAR : r_fld + 3'd1) : r_fld;
`ifdef TIME_SET_TIMEOUT_EN
    logic [7:0] r_idle;
    logic       w_any;
    assign w_any     = btn_mode | btn_next | btn_inc | btn_dec;
    assign w_timeout = r_state == S_EDIT && !w_any && r_idle + 8'd1 >= TIMEOUT;
    always_ff @(posedge clk_1Hz) begin
        if (rst || r_state != S_EDIT || w_any) r_idle <= 8'd0;
        else r_idle <= r_idle + 8'd1;
    end
`else
    assign w_timeout = 1'b0;
`endif
    always_comb begin
        w_state_n = r_state;
        if (r_state == S_IDLE && btn_mode) w_state_n = S_EDIT;
        else if (r_state == S_EDIT && btn_mode) w_state_n = S_COMMIT;
        else if (r_state == S_EDIT && w_timeout) w_state_n = S_IDLE;
        else if (r_state == S_COMMIT) w_state_n = S_IDLE;
    end
    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_fld    <= FLD_YEAR;
            set_sec  <= 6'd0;
            set_min  <= 6'd0;
            set_hour <= 5'd0;
            set_day  <= 5'd1;
            set_mont <= 4'd1;
            set_year <= YEAR_MIN;
        end else begin
            r_state  <= w_state_n;
            r_fld    <= w_fld_n;
            set_sec  <= w_sec_n;
            set_min  <= w_min_n;
            set_hour <= w_hour_n;
            set_day  <= w_day_n;
            set_mont <= w_mont_n;
            set_year <= w_year_n;
        end
    end
    assign load      = r_state == S_COMMIT;
    assign editing   = r_state == S_EDIT;
    assign field_sel = editing ? r_fld : FLD_NONE;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed plus randomized stimulus checked every cycle against a calendar-level model.
module tb_time_set_ctrl;
    logic        clk_1Hz = 1'b0, rst = 1'b1;
    logic        btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [5:0]  cur_sec = '0, cur_min = '0;
    logic [4:0]  cur_hour = '0, cur_day = 5'd1;
    logic [3:0]  cur_mont = 4'd1;
    logic [12:0] cur_year = 13'd2000;
    logic [5:0]  set_sec, set_min;
    logic [4:0]  set_hour, set_day;
    logic [3:0]  set_mont;
    logic [12:0] set_year;
    logic        load, editing;
    logic [2:0]  field_sel;
    localparam int YMIN = 2000, YMAX = 2099;
`ifdef TIME_SET_TIMEOUT_EN
    localparam int TIMEOUT = 30;
`endif
    int n_vec = 0, n_err = 0, n_loads = 0;

    time_set_ctrl dut (.clk_1Hz(clk_1Hz), .rst(rst), .btn_mode(btn_mode), .btn_next(btn_next),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
        .cur_day(cur_day), .cur_mont(cur_mont), .cur_year(cur_year), .set_sec(set_sec), .set_min(set_min),
        .set_hour(set_hour), .set_day(set_day), .set_mont(set_mont), .set_year(set_year),
        .load(load), .editing(editing), .field_sel(field_sel));

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dim(input int mo, input int y);
        int days[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        bit leap = (y % 4 == 0 && y % 100 != 0) || y % 400 == 0;
        return (mo == 2 && leap) ? 29 : days[mo - 1];
    endfunction
    function automatic int clampi(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction
    function automatic int wrap(input int v, input int lo, input int hi, input int st);
        int n = hi - lo + 1;
        return lo + ((v - lo + st) % n + n) % n;
    endfunction

    // Inputs as seen by the posedge, held stable until the next posedge
    logic        s_rst, s_mode, s_next, s_inc, s_dec;
    int          s_y, s_mo, s_d, s_h, s_mi, s_s;
    always @(posedge clk_1Hz) begin
        s_rst <= rst; s_mode <= btn_mode; s_next <= btn_next; s_inc <= btn_inc; s_dec <= btn_dec;
        s_y <= cur_year; s_mo <= cur_mont; s_d <= cur_day; s_h <= cur_hour; s_mi <= cur_min; s_s <= cur_sec;
    end

    // Model: mode 0 browsing, 1 editing, 2 committing
    bit m_valid = 0;
    int m_mode, m_fld, m_idle, m_y, m_mo, m_d, m_h, m_mi, m_s;
    task automatic model_step();
        int st;
        if (s_rst) begin
            m_valid = 1; m_mode = 0; m_fld = 0; m_idle = 0;
            m_y = YMIN; m_mo = 1; m_d = 1; m_h = 0; m_mi = 0; m_s = 0;
        end else if (m_mode == 0) begin
            if (s_mode) begin
                m_y = clampi(s_y, YMIN, YMAX); m_mo = clampi(s_mo, 1, 12);
                m_d = clampi(s_d, 1, dim(m_mo, m_y)); m_h = clampi(s_h, 0, 23);
                m_mi = clampi(s_mi, 0, 59); m_s = clampi(s_s, 0, 59);
                m_fld = 0; m_mode = 1; m_idle = 0;
            end
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else begin
            m_idle = (s_mode | s_next | s_inc | s_dec) ? 0 : m_idle + 1;
            if (s_mode) m_mode = 2;
            else if (s_next) m_fld = (m_fld + 1) % 6;
            else if (s_inc != s_dec) begin
                st = s_inc ? 1 : -1;
                case (m_fld)
                    0: m_y = wrap(m_y, YMIN, YMAX, st);
                    1: m_mo = wrap(m_mo, 1, 12, st);
                    2: m_d = wrap(m_d, 1, dim(m_mo, m_y), st);
                    3: m_h = wrap(m_h, 0, 23, st);
                    4: m_mi = wrap(m_mi, 0, 59, st);
                    default: m_s = wrap(m_s, 0, 59, st);
                endcase
                m_d = clampi(m_d, 1, dim(m_mo, m_y));
            end
`ifdef TIME_SET_TIMEOUT_EN
            if (m_mode == 1 && m_idle >= TIMEOUT) m_mode = 0;
`endif
        end
    endtask

    always @(negedge clk_1Hz) begin
        model_step();
        if (m_valid) begin
            chk("load", load, m_mode == 2);
            chk("editing", editing, m_mode == 1);
            chk("field_sel", field_sel, m_mode == 1 ? m_fld : 7);
            chk("set_year", set_year, m_y);
            chk("set_mont", set_mont, m_mo);
            chk("set_day", set_day, m_d);
            chk("set_hour", set_hour, m_h);
            chk("set_min", set_min, m_mi);
            chk("set_sec", set_sec, m_s);
            if (load) n_loads++;
        end
    end

    task automatic press(input logic m, input logic n, input logic i, input logic d);
        btn_mode = m; btn_next = n; btn_inc = i; btn_dec = d;
        @(negedge clk_1Hz);
        btn_mode = 0; btn_next = 0; btn_inc = 0; btn_dec = 0;
    endtask
    task automatic set_cur(input int y, input int mo, input int d, input int h, input int mi, input int s);
        cur_year = 13'(y); cur_mont = 4'(mo); cur_day = 5'(d); cur_hour = 5'(h); cur_min = 6'(mi); cur_sec = 6'(s);
    endtask

    initial begin
        int loads0;
        repeat (2) @(negedge clk_1Hz);
        rst = 0;
        chk("rst_load", load, 0); chk("rst_editing", editing, 0); chk("rst_field", field_sel, 7);
        chk("rst_year", set_year, 2000); chk("rst_mont", set_mont, 1); chk("rst_day", set_day, 1);
        set_cur(2023, 12, 31, 23, 59, 58);
        press(1, 0, 0, 0);
        chk("t2_editing", editing, 1); chk("t2_field", field_sel, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        chk("t2_load", load, 1); chk("t2_year", set_year, 2024); chk("t2_mont", set_mont, 12);
        chk("t2_day", set_day, 31); chk("t2_hour", set_hour, 23); chk("t2_min", set_min, 59); chk("t2_sec", set_sec, 58);
        press(0, 0, 0, 0);
        chk("t2_load_drop", load, 0);
        set_cur(2024, 2, 29, 0, 0, 0);
        press(1, 0, 0, 0);
        press(0, 0, 0, 1);
        chk("t3_year_dec", set_year, 2023); chk("t3_day_clamp", set_day, 28);
        press(0, 0, 1, 0);
        chk("t3_year_inc", set_year, 2024); chk("t3_day_kept", set_day, 28);
        press(1, 0, 0, 0); press(0, 0, 0, 0);
        set_cur(2099, 12, 15, 10, 0, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        chk("t4_year_wrap", set_year, 2000);
        press(0, 1, 0, 0); press(0, 0, 1, 0);
        chk("t4_mont_wrap", set_mont, 1);
        press(0, 1, 0, 0); press(0, 1, 0, 0); press(0, 1, 0, 0);
        chk("t4_field_min", field_sel, 4);
        press(0, 0, 0, 1);
        chk("t4_min_wrap", set_min, 59);
        press(1, 0, 0, 0); press(0, 0, 0, 0);
        press(1, 0, 0, 0); press(0, 1, 0, 0);
        press(0, 0, 1, 1);
        chk("t5_incdec", set_mont, 12);
        press(1, 1, 0, 0);
        chk("t5_commit", load, 1); chk("t5_mont", set_mont, 12);
        press(0, 0, 0, 0);
        loads0 = n_loads;
        press(1, 0, 0, 0); press(0, 0, 1, 0);
        rst = 1; @(negedge clk_1Hz); rst = 0;
        chk("t6_editing", editing, 0); chk("t6_load", load, 0); chk("t6_year", set_year, 2000); chk("t6_field", field_sel, 7);
        repeat (5) @(negedge clk_1Hz);
        chk("t6_no_load", n_loads, loads0);
        press(1, 0, 0, 0);
`ifdef TIME_SET_TIMEOUT_EN
        repeat (28) @(negedge clk_1Hz);
        press(0, 1, 0, 0);
        repeat (29) @(negedge clk_1Hz);
        chk("to_alive", editing, 1);
        @(negedge clk_1Hz);
        chk("to_expired", editing, 0); chk("to_no_load", n_loads, loads0);
`else
        repeat (40) @(negedge clk_1Hz);
        chk("persist", editing, 1);
        press(1, 0, 0, 0); press(0, 0, 0, 0);
`endif
        repeat (3000) begin
            rst = ($urandom % 300) == 0;
            btn_mode = ($urandom % 8) == 0; btn_next = ($urandom % 5) == 0;
            btn_inc = ($urandom % 3) == 0; btn_dec = ($urandom % 4) == 0;
            set_cur(($urandom % 5 == 0) ? 2000 + 4 * ($urandom % 26) : 1995 + $urandom % 110,
                    $urandom % 16, $urandom % 32, $urandom % 32, $urandom % 64, $urandom % 64);
            @(negedge clk_1Hz);
        end
        rst = 0; btn_mode = 0; btn_next = 0; btn_inc = 0; btn_dec = 0;
        @(negedge clk_1Hz);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
